// File: rtl/multi_byte_add_sequencer.sv
// ============================================================================
// Module      : multi_byte_add_sequencer
// Description : Wide add/subtract sequenced LSB-first through one 8-bit
//               ripple-carry slice, one byte per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_byte_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               op_sub_i,
  input  logic [8*WORDS-1:0] a_i,
  input  logic [8*WORDS-1:0] b_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [8*WORDS-1:0] result_o,
  output logic               cout_o,
  output logic               ovf_o
);

  localparam int W     = 8 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [W-1:0]     opa_q;
  logic [W-1:0]     opb_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [W-1:0]     result_q;
  logic             cout_q;
  logic             ovf_q;

  logic [7:0]       w_a_byte;
  logic [7:0]       w_b_byte;
  logic [7:0]       w_sum;
  logic [8:0]       w_c;

  always_comb begin
    w_a_byte = '0;
    w_b_byte = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_a_byte = opa_q[i*8 +: 8];
        w_b_byte = opb_q[i*8 +: 8];
      end
    end
  end

  // Byte slice: eight full adders, carry-in taken only from the carry register.
  assign w_c[0] = carry_q;

  for (genvar g = 0; g < 8; g++) begin : g_fa
    assign w_sum[g]  = w_a_byte[g] ^ w_b_byte[g] ^ w_c[g];
    assign w_c[g+1]  = (w_a_byte[g] & w_b_byte[g]) | (w_c[g] & (w_a_byte[g] ^ w_b_byte[g]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            opa_q   <= a_i;
            opb_q   <= b_i ^ {W{op_sub_i}};
            carry_q <= op_sub_i;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              result_q[i*8 +: 8] <= w_sum;
            end
          end
          carry_q <= w_c[8];
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(WORDS - 1)) begin
            cout_q  <= w_c[8];
            // Signed overflow: operands agree in sign but the sum does not.
            ovf_q   <= (w_a_byte[7] ~^ w_b_byte[7]) & (w_sum[7] ^ w_a_byte[7]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_byte_add_sequencer.sv
// ============================================================================
// Module      : tb_multi_byte_add_sequencer
// Description : Directed self-checking bench for the sequencer at WORDS=2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_byte_add_sequencer;

  localparam int WORDS = 2;
  localparam int W     = 8 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         op_sub_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         ready_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         cout_o;
  logic         ovf_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_byte_add_sequencer #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_sub_i (op_sub_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .cout_o   (cout_o),
    .ovf_o    (ovf_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and check the full fixed-latency handshake.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic [W-1:0] exp_res,
                       input logic exp_cout, input logic exp_ovf);
    chk({tag, ".ready_pre"}, ready_o, 1);
    start_i  = 1'b1;
    a_i      = a;
    b_i      = b;
    op_sub_i = sub;
    step();
    start_i  = 1'b0;
    a_i      = '0;
    b_i      = '0;
    op_sub_i = 1'b0;
    chk({tag, ".busy1"}, {ready_o, busy_o, done_o}, 3'b010);
    step();
    chk({tag, ".busy2"}, {ready_o, busy_o, done_o}, 3'b010);
    step();
    chk({tag, ".done"},   {ready_o, busy_o, done_o}, 3'b001);
    chk({tag, ".result"}, result_o, exp_res);
    chk({tag, ".cout"},   cout_o, exp_cout);
    chk({tag, ".ovf"},    ovf_o, exp_ovf);
    step();
    chk({tag, ".idle"},   {ready_o, busy_o, done_o}, 3'b100);
    chk({tag, ".held"},   result_o, exp_res);
  endtask

  initial begin
    rst      = 1'b1;
    start_i  = 1'b0;
    op_sub_i = 1'b0;
    a_i      = '0;
    b_i      = '0;
    step();
    step();
    chk("reset.flags",  {ready_o, busy_o, done_o}, 3'b100);
    chk("reset.result", result_o, 0);
    chk("reset.cout",   cout_o, 0);
    chk("reset.ovf",    ovf_o, 0);
    rst = 1'b0;
    step();

    do_op("add_00ff_0001", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("sub_0000_0001", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    do_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("sub_1234_1234", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);

    // start held high with different operands through RUN and DONE
    start_i  = 1'b1;
    a_i      = 16'h1234;
    b_i      = 16'h1111;
    op_sub_i = 1'b0;
    step();
    a_i      = 16'hFFFF;
    b_i      = 16'hFFFF;
    op_sub_i = 1'b1;
    chk("busy_start.run1", {ready_o, busy_o, done_o}, 3'b010);
    step();
    chk("busy_start.run2", {ready_o, busy_o, done_o}, 3'b010);
    step();
    chk("busy_start.done",   {ready_o, busy_o, done_o}, 3'b001);
    chk("busy_start.result", result_o, 16'h2345);
    chk("busy_start.cout",   cout_o, 0);
    start_i = 1'b0;
    step();
    chk("busy_start.idle", {ready_o, busy_o, done_o}, 3'b100);
    step();
    chk("busy_start.nodone", {ready_o, busy_o, done_o}, 3'b100);
    chk("busy_start.held",   result_o, 16'h2345);

    // reset during the first RUN cycle
    start_i  = 1'b1;
    a_i      = 16'hAAAA;
    b_i      = 16'h5555;
    op_sub_i = 1'b0;
    step();
    start_i = 1'b0;
    chk("rst_mid.busy", busy_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid.flags",  {ready_o, busy_o, done_o}, 3'b100);
    chk("rst_mid.result", result_o, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_mid.nodone", {ready_o, busy_o, done_o}, 3'b100);
    end

    do_op("after_rst", 16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
